// File: rtl/branch_predict_unit.sv
// Dynamic branch predictor: direct-mapped BTB with per-entry saturating counters and mispredict redirect.
// Optional branch/mispredict statistics counters are enabled with `define BPU_STATS_EN.
module branch_predict_unit #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pcF,
  output logic            pred_takenF,
  output logic [XLEN-1:0] next_pcF,
  input  logic            BranchE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCplus4E,
  input  logic [XLEN-1:0] PCtargetE,
  input  logic            takenE,
  input  logic            pred_takenE,
  input  logic [XLEN-1:0] pred_targetE,
  output logic            mispredictE,
  output logic [XLEN-1:0] redirect_pcE,
  output logic            FlushD,
  output logic            FlushE
`ifdef BPU_STATS_EN
  ,
  output logic [31:0]     br_countO,
  output logic [31:0]     mispred_countO
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  typedef logic [CTR_W-1:0] ctr_t;
  localparam ctr_t CTR_MAX = '1;
  localparam ctr_t CTR_WT  = ctr_t'(1) << (CTR_W - 1);
  localparam ctr_t CTR_WNT = CTR_WT - ctr_t'(1);

  logic             validQ  [ENTRIES];
  logic [TAG_W-1:0] tagQ    [ENTRIES];
  logic [XLEN-1:0]  targetQ [ENTRIES];
  ctr_t             ctrQ    [ENTRIES];

  logic [IDX_W-1:0] idxF, idxE;
  logic [TAG_W-1:0] tagF, tagE;
  logic             hitF, hitE;
  logic             unusedPceLow;

  assign idxF = pcF[IDX_W+1:2];
  assign tagF = pcF[XLEN-1:IDX_W+2];
  assign idxE = PCE[IDX_W+1:2];
  assign tagE = PCE[XLEN-1:IDX_W+2];
  assign unusedPceLow = ^PCE[1:0];

  // Lookup reads the registered table, so a same-cycle update to the same index is not bypassed.
  assign hitF        = validQ[idxF] && (tagQ[idxF] == tagF);
  assign pred_takenF = hitF && ctrQ[idxF][CTR_W-1];
  assign next_pcF    = pred_takenF ? targetQ[idxF] : pcF + XLEN'(4);

  assign hitE = validQ[idxE] && (tagQ[idxE] == tagE);

  // Resolution outputs are held quiet while reset is asserted.
  assign mispredictE  = rst && BranchE &&
                        ((takenE != pred_takenE) || (takenE && (pred_targetE != PCtargetE)));
  assign redirect_pcE = (rst && takenE) ? PCtargetE : PCplus4E;
  assign FlushD       = mispredictE;
  assign FlushE       = mispredictE;

  // NOTE: every table entry is reset so stale targets/counters never leak out after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validQ[i]  <= 1'b0;
        tagQ[i]    <= '0;
        targetQ[i] <= '0;
        ctrQ[i]    <= CTR_WNT;
      end
    end else if (BranchE) begin
      if (hitE) begin
        if (takenE) begin
          if (ctrQ[idxE] != CTR_MAX) ctrQ[idxE] <= ctrQ[idxE] + ctr_t'(1);
          targetQ[idxE] <= PCtargetE;
        end else if (ctrQ[idxE] != '0) begin
          ctrQ[idxE] <= ctrQ[idxE] - ctr_t'(1);
        end
      end else if (takenE) begin
        validQ[idxE]  <= 1'b1;
        tagQ[idxE]    <= tagE;
        targetQ[idxE] <= PCtargetE;
        ctrQ[idxE]    <= CTR_WT;
      end
    end
  end

`ifdef BPU_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_countO      <= '0;
      mispred_countO <= '0;
    end else begin
      if (BranchE)     br_countO      <= br_countO + 32'd1;
      if (mispredictE) mispred_countO <= mispred_countO + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: directed scenarios plus random traffic vs. a table model.
module tb_branch_predict_unit;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int CTR_W   = 2;
  localparam int MAXC    = (1 << CTR_W) - 1;
  localparam int TAKEN_THRESH = 1 << (CTR_W - 1);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [XLEN-1:0] pcF = '0;
  logic            pred_takenF;
  logic [XLEN-1:0] next_pcF;
  logic            BranchE = 1'b0;
  logic [XLEN-1:0] PCE = '0, PCplus4E = '0, PCtargetE = '0, pred_targetE = '0;
  logic            takenE = 1'b0, pred_takenE = 1'b0;
  logic            mispredictE;
  logic [XLEN-1:0] redirect_pcE;
  logic            FlushD, FlushE;
`ifdef BPU_STATS_EN
  logic [31:0]     br_countO, mispred_countO;
`endif

  branch_predict_unit #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_W(CTR_W)) dut (
    .clk(clk), .rst(rst), .pcF(pcF), .pred_takenF(pred_takenF), .next_pcF(next_pcF),
    .BranchE(BranchE), .PCE(PCE), .PCplus4E(PCplus4E), .PCtargetE(PCtargetE),
    .takenE(takenE), .pred_takenE(pred_takenE), .pred_targetE(pred_targetE),
    .mispredictE(mispredictE), .redirect_pcE(redirect_pcE), .FlushD(FlushD), .FlushE(FlushE)
`ifdef BPU_STATS_EN
    , .br_countO(br_countO), .mispred_countO(mispred_countO)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    int unsigned tag;
    bit [31:0]   target;
    int          ctr;
  } ent_t;

  typedef struct {
    bit        predTaken;
    bit [31:0] nextPc;
    bit        mis;
    bit [31:0] redirect;
    bit [31:0] brCnt;
    bit [31:0] misCnt;
  } exp_t;

  ent_t        mdl [ENTRIES];
  exp_t        sbq [$];
  int unsigned brCount, misCount;
  int          checks = 0, errors = 0;
  bit          txnValid = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int idxOf(bit [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned tagOf(bit [31:0] pc);
    return pc >> ($clog2(ENTRIES) + 2);
  endfunction

  function automatic bit mdlHit(bit [31:0] pc);
    return mdl[idxOf(pc)].valid && (mdl[idxOf(pc)].tag == tagOf(pc));
  endfunction

  function automatic bit mdlPred(bit [31:0] pc);
    return mdlHit(pc) && (mdl[idxOf(pc)].ctr >= TAKEN_THRESH);
  endfunction

  function automatic bit [31:0] mdlNext(bit [31:0] pc);
    return mdlPred(pc) ? mdl[idxOf(pc)].target : pc + 32'd4;
  endfunction

  task automatic mdlClear();
    for (int i = 0; i < ENTRIES; i++) begin
      mdl[i].valid = 0; mdl[i].tag = 0; mdl[i].target = 0; mdl[i].ctr = TAKEN_THRESH - 1;
    end
    brCount = 0; misCount = 0;
  endtask

  // Apply one cycle of stimulus, queue its expected outputs, then advance the model past the edge.
  task automatic drive(bit [31:0] pc, bit br, bit [31:0] pce, bit [31:0] tgt,
                       bit tk, bit pt, bit [31:0] ptgt);
    exp_t e;
    int   i;
    pcF = pc; BranchE = br; PCE = pce; PCplus4E = pce + 32'd4; PCtargetE = tgt;
    takenE = tk; pred_takenE = pt; pred_targetE = ptgt;
    e.predTaken = mdlPred(pc);
    e.nextPc    = mdlNext(pc);
    e.mis       = br && ((tk != pt) || (tk && ptgt != tgt));
    e.redirect  = tk ? tgt : pce + 32'd4;
    e.brCnt     = brCount;
    e.misCnt    = misCount;
    sbq.push_back(e);
    txnValid = 1;
    if (br) begin
      i = idxOf(pce);
      if (mdlHit(pce)) begin
        if (tk) begin
          mdl[i].ctr = (mdl[i].ctr == MAXC) ? MAXC : mdl[i].ctr + 1;
          mdl[i].target = tgt;
        end else begin
          mdl[i].ctr = (mdl[i].ctr == 0) ? 0 : mdl[i].ctr - 1;
        end
      end else if (tk) begin
        mdl[i].valid = 1; mdl[i].tag = tagOf(pce); mdl[i].target = tgt; mdl[i].ctr = TAKEN_THRESH;
      end
      brCount++;
      if (e.mis) misCount++;
    end
  endtask

  task automatic nextCycle();
    @(posedge clk); #1;
  endtask

  task automatic probe(string name, bit [31:0] pc, bit expPred, bit [31:0] expNext);
    drive(pc, 0, 0, 0, 0, 0, 0);
    #1;
    check({name, "_pred"}, pred_takenF, expPred);
    check({name, "_next"}, next_pcF, expNext);
    nextCycle();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (txnValid) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow: got empty queue expected an entry at %0t", $time);
      end else begin
        e = sbq.pop_front();
        check("sb_pred_takenF", pred_takenF, e.predTaken);
        check("sb_next_pcF", next_pcF, e.nextPc);
        check("sb_mispredictE", mispredictE, e.mis);
        check("sb_redirect_pcE", redirect_pcE, e.redirect);
        check("sb_FlushD", FlushD, e.mis);
        check("sb_FlushE", FlushE, e.mis);
`ifdef BPU_STATS_EN
        check("sb_br_countO", br_countO, e.brCnt);
        check("sb_mispred_countO", mispred_countO, e.misCnt);
`endif
      end
    end
  end

  initial begin
    bit [31:0] pc, pce, tgt, ptgt;
    bit        tk, pt;
    mdlClear();

    // Reset state, including a branch presented while reset is held.
    pcF = 32'h40; BranchE = 1; PCE = 32'h40; PCplus4E = 32'h44; PCtargetE = 32'h80;
    takenE = 1; pred_takenE = 0; pred_targetE = 32'h44;
    #3;
    check("rst_pred_takenF", pred_takenF, 0);
    check("rst_next_pcF", next_pcF, 32'h44);
    check("rst_mispredictE", mispredictE, 0);
    check("rst_FlushD", FlushD, 0);
    check("rst_redirect_pcE", redirect_pcE, 32'h44);
`ifdef BPU_STATS_EN
    check("rst_br_count", br_countO, 0);
    check("rst_mispred_count", mispred_countO, 0);
`endif
    @(posedge clk); #1;
    rst = 1;

    // First taken branch: miss, mispredict, allocate.
    drive(32'h40, 1, 32'h40, 32'h80, 1, 0, 32'h44);
    #1;
    check("d1_pred", pred_takenF, 0);
    check("d1_next", next_pcF, 32'h44);
    check("d1_mis", mispredictE, 1);
    check("d1_redirect", redirect_pcE, 32'h80);
    check("d1_flush", {FlushD, FlushE}, 2'b11);
    nextCycle();

    drive(32'h40, 1, 32'h40, 32'h80, 1, 1, 32'h80);
    #1;
    check("d2_pred", pred_takenF, 1);
    check("d2_next", next_pcF, 32'h80);
    check("d2_mis", mispredictE, 0);
    nextCycle();

    // Saturate high, then walk down and saturate low.
    repeat (3) begin drive(32'h0, 1, 32'h40, 32'h80, 1, 1, 32'h80); nextCycle(); end
    repeat (2) begin drive(32'h0, 1, 32'h40, 32'h80, 0, 1, 32'h80); nextCycle(); end
    probe("sat_weak_nt", 32'h40, 0, 32'h44);
    drive(32'h0, 1, 32'h40, 32'h80, 0, 0, 32'h44); nextCycle();
    probe("still_target", 32'h40, 0, 32'h44);
    repeat (2) begin drive(32'h0, 1, 32'h40, 32'h80, 0, 0, 32'h44); nextCycle(); end
    drive(32'h0, 1, 32'h40, 32'h80, 1, 0, 32'h44); nextCycle();
    probe("sat_low_hold", 32'h40, 0, 32'h44);
    drive(32'h0, 1, 32'h40, 32'h80, 1, 0, 32'h44); nextCycle();
    probe("sat_low_recover", 32'h40, 1, 32'h80);

    // Alias: 0x80 shares index 0 with 0x40 and evicts it.
    drive(32'h0, 1, 32'h80, 32'h200, 1, 0, 32'h84); nextCycle();
    probe("alias_evicted", 32'h40, 0, 32'h44);
    probe("alias_new", 32'h80, 1, 32'h200);

    // Same-cycle lookup and update to the same index: old contents seen.
    drive(32'h40, 1, 32'h40, 32'h300, 1, 0, 32'h44);
    #1;
    check("coll_old_pred", pred_takenF, 0);
    check("coll_old_next", next_pcF, 32'h44);
    nextCycle();
    probe("coll_new", 32'h40, 1, 32'h300);

    // Reset asserted across an update edge: update discarded, table cleared.
    drive(32'h0, 1, 32'h80, 32'h500, 1, 0, 32'h84);
    @(negedge clk); #2;
    rst = 0;
    mdlClear();
    @(posedge clk); #1;
    check("midrst_mis", mispredictE, 0);
    check("midrst_redirect", redirect_pcE, 32'h84);
    rst = 1;
    probe("midrst_80", 32'h80, 0, 32'h84);
    probe("midrst_40", 32'h40, 0, 32'h44);

    // Five branches, two of them mispredicted.
    drive(32'h0, 1, 32'h100, 32'h180, 1, 0, 32'h104); nextCycle();
    drive(32'h0, 1, 32'h100, 32'h180, 1, 1, 32'h180); nextCycle();
    drive(32'h0, 1, 32'h100, 32'h180, 0, 0, 32'h104); nextCycle();
    drive(32'h0, 1, 32'h100, 32'h180, 0, 1, 32'h180); nextCycle();
    drive(32'h0, 1, 32'h100, 32'h180, 1, 1, 32'h180); nextCycle();
`ifdef BPU_STATS_EN
    check("stats_br5", br_countO, 5);
    check("stats_mis2", mispred_countO, 2);
`endif

    // Random traffic over a small address window to exercise hits, misses and aliasing.
    for (int n = 0; n < 400; n++) begin
      pc  = 32'h1000 + ($urandom_range(0, 63) << 2);
      pce = 32'h1000 + ($urandom_range(0, 63) << 2);
      tgt = $urandom & 32'hFFFF_FFFC;
      tk  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 6) begin
        pt = mdlPred(pce); ptgt = mdlNext(pce);
      end else begin
        pt = 1'($urandom_range(0, 1));
        ptgt = ($urandom_range(0, 1) != 0) ? tgt : ($urandom & 32'hFFFF_FFFC);
      end
      drive(pc, 1'($urandom_range(0, 3) != 0), pce, tgt, tk, pt, ptgt);
      nextCycle();
    end
    txnValid = 0;
    BranchE = 0;

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised dynamic branch predictor and redirect controller for the 5-stage RISC-V pipeline. It supersedes the static stall-and-flush branch handling. It combines a direct-mapped branch target buffer (BTB) with a per-entry saturating-counter history table. Fetch is served with a same-cycle next-PC prediction; branches resolved in Execute update the tables, and the unit generates the redirect and flush on a mispredict.

## Interface
Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 16, BTB/counter entries; power of two, ≥2.
- CTR_W, 2, saturating counter width (≥2); MSB=1 means predict taken.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  asynchronous, active-low reset.
- pcF  input  XLEN  current fetch PC.
- pred_takenF  output  1  fetch-stage prediction.
- next_pcF  output  XLEN  predicted next PC: stored target if pred_takenF, else pcF+4.
- BranchE  input  1  valid branch/jump resolving in Execute this cycle.
- PCE  input  XLEN  PC of the resolving instruction.
- PCplus4E  input  XLEN  PCE+4.
- PCtargetE  input  XLEN  computed target.
- takenE  input  1  actual outcome (PCsrcE).
- pred_takenE  input  1  prediction carried down the pipeline with the instruction.
- pred_targetE  input  XLEN  next_pcF value carried with the instruction.
- mispredictE  output  1  redirect required.
- redirect_pcE  output  XLEN  correct next PC.
- FlushD  output  1  flush the IF/ID register.
- FlushE  output  1  flush the ID/EX register.

## Operation
- Index = PC[IDX_W+1:2], where IDX_W = log2(ENTRIES). Tag = PC[XLEN-1:IDX_W+2].
- Each entry holds: valid, tag, target[XLEN], ctr[CTR_W].
- Lookup (combinational on pcF):
  - hit = valid && tag match.
  - pred_takenF = hit && ctr[MSB].
- Mispredict: mispredictE = BranchE && ((takenE != pred_takenE) || (takenE && pred_targetE != PCtargetE)).
- redirect_pcE = takenE ? PCtargetE : PCplus4E.
- FlushD = FlushE = mispredictE. All three are combinational and zero when BranchE=0.
- Update on the rising clk edge when BranchE=1, at the PCE entry:
  - Hit, taken: ctr saturating increment; target <= PCtargetE.
  - Hit, not taken: ctr saturating decrement; target unchanged.
  - Miss, taken: allocate or overwrite. valid=1, tag, target=PCtargetE, ctr=weakly-taken (MSB=1, rest 0).
  - Miss, not taken: no change.
- Counter saturates at all-ones and zero; it never wraps.

## Timing
- Prediction latency is 0 cycles: next_pcF is valid in the same cycle as pcF.
- Tables update 1 cycle after BranchE; the new state is visible to lookups on the following cycle.
- Lookup and update hitting the same index in the same cycle: the lookup sees the pre-update contents (no bypass).
- Reset (rst=0, asynchronous):
  - All valid bits clear; ctr resets to weakly-not-taken (MSB=0, rest 1); target resets to 0.
  - Outputs: pred_takenF=0, next_pcF=pcF+4, mispredictE/FlushD/FlushE=0, redirect_pcE=PCplus4E.
- Reset asserted mid-update: the update is discarded. Deassertion is synchronised externally.
- BranchE asserted on consecutive cycles: each update applies independently, in order.

## Configuration
- BPU_STATS_EN defined:
  - Adds output ports br_countO[31:0] and mispred_countO[31:0], registered and reset to 0.
  - br_countO increments on each BranchE. mispred_countO increments on each mispredictE.
  - Both wrap modulo 2^32.
- BPU_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then pcF=0x40 → pred_takenF=0, next_pcF=0x44. BranchE with PCE=0x40, takenE=1, PCtargetE=0x80, pred_takenE=0 → mispredictE=1, redirect_pcE=0x80, FlushD=FlushE=1.
- Next cycle, pcF=0x40 → pred_takenF=1, next_pcF=0x80. Resolve taken with pred_targetE=0x80 → mispredictE=0.
- Saturation (CTR_W=2):
  - Resolve 0x40 taken 3 more times → ctr=11.
  - Then resolve not-taken twice → ctr=01; pcF=0x40 predicts not taken.
  - Further not-taken resolves hold ctr at 00.
- Alias (ENTRIES=16): allocate 0x40 (target 0x80), then allocate 0x80 (target 0x200; same index, different tag). pcF=0x40 → miss, next_pcF=0x44.
- Same-cycle collision: pcF=0x40 and BranchE update to 0x40 in the same cycle → lookup returns the old entry; the new entry appears next cycle. Assert rst during a BranchE → all entries invalid afterwards.
- BPU_STATS_EN: 5 branches with 2 mispredicts → br_countO=5, mispred_countO=2. Reset → both 0.
